// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// | Module      : npu_pkg                                                    |
// | Description : Shared constants and types for the convolution datapath.  |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
package npu_pkg;

    // Default pixel width used across the datapath
    localparam int DEFAULT_BIT_DEPTH = 8;

    // Convolution window edge length (3x3 neighbourhood)
    localparam int WIN_SIZE = 3;

    // Line buffer feeder control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// | Module      : line_ram                                                   |
// | Description : Single-port DEPTH x WIDTH row store with synchronous       |
// |               read-before-write and a resettable read register.          |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module line_ram #(
    parameter int DEPTH  = 28,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array write; contents are never cleared so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register captures the old word at the addressed location (read-before-write)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/line_buffer_feeder.sv
`default_nettype none
// ============================================================================
// | Module      : line_buffer_feeder                                         |
// | Description : Raster-to-column converter feeding the 3x3 window shift    |
// |               register; emits three vertically aligned pixels per column.|
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module line_buffer_feeder
    import npu_pkg::*;
#(
    parameter int BIT_DEPTH  = DEFAULT_BIT_DEPTH,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_valid,
    input  logic [BIT_DEPTH-1:0] pix_in,
    output logic                 pix_ready,
    output logic [BIT_DEPTH-1:0] col_out1,
    output logic [BIT_DEPTH-1:0] col_out2,
    output logic [BIT_DEPTH-1:0] col_out3,
    output logic                 col_valid,
    output logic                 win_full,
    output logic                 frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_COL_EDGE = COL_W'(WIN_SIZE - 1);
    localparam logic [ROW_W-1:0] c_ROW_EDGE = ROW_W'(WIN_SIZE - 1);
    localparam logic [ROW_W-1:0] c_ROW_FILL = ROW_W'(WIN_SIZE - 2);

    feeder_state_t        state_q;
    logic [COL_W-1:0]     col_idx_q, col_idx_d;
    logic [ROW_W-1:0]     row_idx_q, row_idx_d;
    logic                 pix_ready_q;
    logic [BIT_DEPTH-1:0] col3_q;
    logic                 swap_q;
    logic                 col_valid_q;
    logic                 win_full_q;
    logic                 frame_done_q;

    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_frame_last;
    logic                 w_fill_last;
    logic                 w_stream_row;
    logic                 w_odd_row;
    logic [BIT_DEPTH-1:0] w_lb0_rdata;
    logic [BIT_DEPTH-1:0] w_lb1_rdata;

    // Acceptance, position decode and next raster position
    always_comb begin
        w_accept     = pix_valid & pix_ready_q;
        w_col_last   = (col_idx_q == c_COL_LAST);
        w_row_last   = (row_idx_q == c_ROW_LAST);
        w_frame_last = w_col_last & w_row_last;
        w_fill_last  = w_col_last & (row_idx_q == c_ROW_FILL);
        w_stream_row = (row_idx_q >= c_ROW_EDGE);
        w_odd_row    = row_idx_q[0];
        col_idx_d    = col_idx_q;
        row_idx_d    = row_idx_q;
        if (w_accept) begin
            if (w_col_last) begin
                col_idx_d = '0;
                row_idx_d = w_row_last ? '0 : (row_idx_q + 1'b1);
            end else begin
                col_idx_d = col_idx_q + 1'b1;
            end
        end
    end

    // The two row stores alternate roles by row parity: each row overwrites the
    // store holding row r-2 at the same address it reads, so every access is a
    // plain single-port read-before-write and no row-to-row copy is needed.
    // lb0 takes even rows, lb1 takes odd rows.
    line_ram #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (BIT_DEPTH),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_accept),
        .we_i    (~w_odd_row),
        .addr_i  (col_idx_q),
        .wdata_i (pix_in),
        .rdata_o (w_lb0_rdata)
    );

    line_ram #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (BIT_DEPTH),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_accept),
        .we_i    (w_odd_row),
        .addr_i  (col_idx_q),
        .wdata_i (pix_in),
        .rdata_o (w_lb1_rdata)
    );

    // Control FSM, raster counters and registered column outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            pix_ready_q  <= 1'b1;
            col3_q       <= '0;
            swap_q       <= 1'b0;
            col_valid_q  <= 1'b0;
            win_full_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
            col_valid_q  <= w_accept & w_stream_row;
            win_full_q   <= w_accept & w_stream_row & (col_idx_q >= c_COL_EDGE);
            frame_done_q <= w_accept & w_frame_last;
            pix_ready_q  <= 1'b1;
            if (w_accept) begin
                col3_q <= pix_in;
                // On odd rows lb1 holds the older row, so the read data swap lanes
                swap_q <= w_odd_row;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_accept && w_fill_last) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept && w_frame_last) begin
                        state_q     <= ST_DONE;
                        pix_ready_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_ready  = pix_ready_q;
    assign col_out1   = swap_q ? w_lb1_rdata : w_lb0_rdata;
    assign col_out2   = swap_q ? w_lb0_rdata : w_lb1_rdata;
    assign col_out3   = col3_q;
    assign col_valid  = col_valid_q;
    assign win_full   = win_full_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// | Module      : tb_line_buffer_feeder                                      |
// | Description : Self-checking bench: 4x4 instance against a raster-level   |
// |               reference model, plus a 3x3 corner instance.               |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_line_buffer_feeder;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       pix_ready, col_valid, win_full, frame_done;
    logic [7:0] col_out1, col_out2, col_out3;

    logic       pix_valid3;
    logic [7:0] pix_in3;
    logic       pix_ready3, col_valid3, win_full3, frame_done3;
    logic [7:0] c3_out1, c3_out2, c3_out3;

    int checks = 0;
    int errors = 0;

    line_buffer_feeder #(.BIT_DEPTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_ready(pix_ready), .col_out1(col_out1), .col_out2(col_out2),
        .col_out3(col_out3), .col_valid(col_valid), .win_full(win_full),
        .frame_done(frame_done)
    );

    line_buffer_feeder #(.BIT_DEPTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid3), .pix_in(pix_in3),
        .pix_ready(pix_ready3), .col_out1(c3_out1), .col_out2(c3_out2),
        .col_out3(c3_out3), .col_valid(col_valid3), .win_full(win_full3),
        .frame_done(frame_done3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (raster index arithmetic) -------------
    int         m_k;
    logic [7:0] img [H][W];
    bit         m_run = 1'b0;
    bit         m_ready, m_known;
    logic       m_valid, m_wf, m_fd;
    logic [7:0] m_c1, m_c2, m_c3;

    always @(posedge clk) begin
        bit acc;
        int r, c;
        if (!rst_n) begin
            m_k = 0; m_ready = 1'b1; m_known = 1'b1; m_run = 1'b1;
            m_valid = 1'b0; m_wf = 1'b0; m_fd = 1'b0;
            m_c1 = 8'h00; m_c2 = 8'h00; m_c3 = 8'h00;
        end else if (m_run) begin
            acc = pix_valid && m_ready;
            m_valid = 1'b0; m_wf = 1'b0; m_fd = 1'b0; m_ready = 1'b1;
            if (acc) begin
                r = m_k / W;
                c = m_k % W;
                img[r][c] = pix_in;
                m_c3 = pix_in;
                if (r >= 2) begin
                    m_c1 = img[r-2][c];
                    m_c2 = img[r-1][c];
                    m_known = 1'b1;
                    m_valid = 1'b1;
                    m_wf = (c >= 2);
                end else begin
                    m_known = 1'b0;
                end
                if (m_k == NPIX - 1) begin
                    m_fd = 1'b1; m_k = 0; m_ready = 1'b0;
                end else begin
                    m_k++;
                end
            end
        end
    end

    // Previous-cycle acceptance as seen by the DUT's handshake
    bit acc_prev = 1'b0;
    always @(posedge clk) acc_prev = rst_n && pix_valid && pix_ready;

    // ---------------- compare process + recorders ---------------------------
    logic [25:0] rec [$];
    int cv_cnt = 0, wf_cnt = 0, fd_cnt = 0, nrdy_cnt = 0;

    always @(negedge clk) begin
        if (m_run) begin
            check("pix_ready", pix_ready, m_ready);
            check("col_valid", col_valid, m_valid);
            check("win_full", win_full, m_wf);
            check("frame_done", frame_done, m_fd);
            check("col_out3", col_out3, m_c3);
            if (m_known) begin
                check("col_out1", col_out1, m_c1);
                check("col_out2", col_out2, m_c2);
            end
            if (col_valid) begin
                check("cv_after_accept", acc_prev, 1'b1);
                rec.push_back({col_out1, col_out2, col_out3, win_full, frame_done});
                cv_cnt++;
            end
            if (win_full) wf_cnt++;
            if (frame_done) fd_cnt++;
            if (rst_n && !pix_ready) nrdy_cnt++;
        end
    end

    logic [23:0] rec3 [$];
    int cv3 = 0, wf3 = 0, fd3 = 0, nrdy3 = 0, wf3_pos = -1, fd3_pos = -1;

    always @(negedge clk) begin
        if (m_run && rst_n) begin
            if (!pix_ready3) nrdy3++;
            if (col_valid3) begin
                rec3.push_back({c3_out1, c3_out2, c3_out3});
                if (win_full3) begin wf3++; wf3_pos = cv3; end
                if (frame_done3) begin fd3++; fd3_pos = cv3; end
                cv3++;
            end
        end
    end

    // ---------------- drivers (called at negedge) ---------------------------
    task automatic send(input logic [7:0] d, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            pix_valid = 1'b0;
            @(negedge clk);
        end
        pix_valid = 1'b1;
        pix_in    = d;
        t = 0;
        while (pix_ready !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 20) begin
                checks++; errors++;
                $display("FAIL send_timeout: pix_ready stuck at %b, wanted 1", pix_ready);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] off, input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(8'(r * 16 + c) + off, gap);
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rec();
        rec.delete();
        cv_cnt = 0; wf_cnt = 0; fd_cnt = 0; nrdy_cnt = 0;
    endtask

    task automatic pulse_reset(input bit v);
        rst_n = 1'b0;
        pix_valid = v;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------------------------------------
    logic [25:0] ref_q [$];

    initial begin
        rst_n = 1'b0; pix_valid = 1'b1; pix_in = 8'hAB;
        pix_valid3 = 1'b0; pix_in3 = 8'h00;
        repeat (3) @(negedge clk);
        // Reset held with pix_valid=1: nothing captured, no strobes
        check("rst_c3", col_out3, 8'h00);
        check("rst_cv", col_valid, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_ready", pix_ready, 1'b1);
        check("post_rst_c1", col_out1, 8'h00);
        check("post_rst_c2", col_out2, 8'h00);
        check("post_rst_c3", col_out3, 8'h00);

        // Continuous frame
        clear_rec();
        send_frame(8'h00, 0);
        idle(3);
        check("cont_cv_count", cv_cnt, 8);
        check("cont_wf_count", wf_cnt, 4);
        check("cont_fd_count", fd_cnt, 1);
        check("cont_len", rec.size(), 8);
        if (rec.size() == 8) begin
            check("cont_first", rec[0], {8'h00, 8'h10, 8'h20, 2'b00});
            check("cont_third", rec[2], {8'h02, 8'h12, 8'h22, 2'b10});
            check("cont_last", rec[7], {8'h13, 8'h23, 8'h33, 2'b11});
        end
        ref_q = rec;

        // Bubbles: valid every other cycle, identical column sequence
        clear_rec();
        send_frame(8'h00, 1);
        idle(3);
        check("bub_len", rec.size(), ref_q.size());
        if (rec.size() == ref_q.size())
            for (int i = 0; i < rec.size(); i++) check("bub_col", rec[i], ref_q[i]);

        // Back-to-back frames, second offset by 0x80
        clear_rec();
        send_frame(8'h00, 0);
        send_frame(8'h80, 0);
        idle(3);
        check("b2b_ready_low", nrdy_cnt, 2);
        check("b2b_len", rec.size(), 16);
        if (rec.size() == 16) begin
            check("b2b_f2_first", rec[8], {8'h80, 8'h90, 8'hA0, 2'b00});
            check("b2b_f2_last", rec[15], {8'h93, 8'hA3, 8'hB3, 2'b11});
        end

        // Reset mid-frame after pixel (2,1)
        for (int i = 0; i < 10; i++) send(8'(((i / W) * 16) + (i % W)), 0);
        pulse_reset(1'b0);
        idle(1);
        check("mid_rst_ready", pix_ready, 1'b1);
        check("mid_rst_c1", col_out1, 8'h00);
        check("mid_rst_c2", col_out2, 8'h00);
        check("mid_rst_c3", col_out3, 8'h00);
        check("mid_rst_cv", col_valid, 1'b0);
        clear_rec();
        send_frame(8'h40, 0);
        idle(3);
        check("mid_rst_len", rec.size(), 8);
        if (rec.size() == 8)
            check("mid_rst_first", rec[0], {8'h40, 8'h50, 8'h60, 2'b00});

        // Randomized traffic with occasional resets, checked by the model
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                if ($urandom_range(0, 99) == 0) pulse_reset(1'($urandom_range(0, 1)));
                send(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        // 3x3 corner instance
        nrdy3 = 0;
        for (int i = 0; i < 9; i++) begin
            pix_valid3 = 1'b1;
            pix_in3 = 8'(((i / 3) * 16) + (i % 3));
            @(negedge clk);
        end
        pix_valid3 = 1'b0;
        repeat (4) @(negedge clk);
        check("c3_cv_count", cv3, 3);
        check("c3_wf_count", wf3, 1);
        check("c3_fd_count", fd3, 1);
        check("c3_wf_pos", wf3_pos, 2);
        check("c3_fd_pos", fd3_pos, 2);
        check("c3_ready_low", nrdy3, 1);
        if (rec3.size() == 3) begin
            check("c3_col0", rec3[0], {8'h00, 8'h10, 8'h20});
            check("c3_col2", rec3[2], {8'h02, 8'h12, 8'h22});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
